// File: rtl/alu_test_console_pkg.sv
// Shared definitions for the ALU test console: opcode table, display characters
// and flag bit positions used by the ALU and the text display.
package alu_test_console_pkg;

    typedef enum logic [7:0] {
        OPC_ADD = 8'h10,
        OPC_AND = 8'h20,
        OPC_CMP = 8'h30,
        OPC_LSH = 8'h40,
        OPC_OR  = 8'h50,
        OPC_SUB = 8'h60,
        OPC_XOR = 8'h70
    } opcode_e;

    localparam int OP_TABLE_LEN  = 7;

    localparam int FLAG_CARRY    = 0;
    localparam int FLAG_LOW      = 1;
    localparam int FLAG_FLAG     = 2;
    localparam int FLAG_Z        = 3;
    localparam int FLAG_NEGATIVE = 4;

    // Indices past the populated table map to 0 so a larger NUM_OPS stays defined.
    function automatic logic [7:0] op_table(input logic [3:0] idx);
        case (idx)
            4'd0:    op_table = OPC_ADD;
            4'd1:    op_table = OPC_AND;
            4'd2:    op_table = OPC_CMP;
            4'd3:    op_table = OPC_LSH;
            4'd4:    op_table = OPC_OR;
            4'd5:    op_table = OPC_SUB;
            4'd6:    op_table = OPC_XOR;
            default: op_table = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] op_char(input logic [3:0] idx);
        case (idx)
            4'd0:    op_char = "+";
            4'd1:    op_char = "&";
            4'd2:    op_char = "?";
            4'd3:    op_char = "<";
            4'd4:    op_char = "|";
            4'd5:    op_char = "-";
            4'd6:    op_char = "^";
            default: op_char = " ";
        endcase
    endfunction

endpackage

// File: rtl/alu_test_console_edge_pulse.sv
// Rising-edge detector: one-cycle registered pulse on a 0->1 input transition.
// The history register resets high so a level held across reset gives no pulse.
module edge_pulse (
    input  logic clk,
    input  logic reset_n,
    input  logic level_i,
    output logic pulse_o
);

    logic level_q;
    logic pulse_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= 1'b1;
            pulse_q <= 1'b0;
        end else begin
            level_q <= level_i;
            pulse_q <= level_i & ~level_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/alu_test_console.sv
// Operand/opcode controller for on-board ALU testing with a newest-first
// history ring of executed results for the text display.
module alu_test_console
    import alu_test_console_pkg::*;
#(
    parameter int               WIDTH   = 16,
    parameter int               DEPTH   = 8,
    parameter int               NUM_OPS = 7,
    parameter int               FLAG_W  = 5,
    parameter logic [WIDTH-1:0] INIT_A  = 16'hCAFE,
    parameter logic [WIDTH-1:0] INIT_B  = 16'h1234
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [7:0]                     sw,
    input  logic                           load_a,
    input  logic                           load_b,
    input  logic                           op_next,
    input  logic                           op_prev,
    input  logic                           exec,
    input  logic [WIDTH-1:0]               alu_result,
    input  logic [FLAG_W-1:0]              alu_flags,
    input  logic [$clog2(DEPTH)-1:0]       hist_sel,
    output logic [WIDTH-1:0]               a,
    output logic [WIDTH-1:0]               b,
    output logic [7:0]                     opcode,
    output logic [3:0]                     op_index,
    output logic [$clog2(WIDTH/8):0]       ptr_a,
    output logic [$clog2(WIDTH/8):0]       ptr_b,
    output logic [$clog2(DEPTH):0]         hist_count,
    output logic                           hist_valid,
    output logic [WIDTH-1:0]               hist_result,
    output logic [FLAG_W-1:0]              hist_flags,
    output logic [3:0]                     hist_op
);

    localparam int NBYTES = WIDTH / 8;
    localparam int PW     = $clog2(NBYTES) + 1;
    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = AW + 1;
    localparam int EW     = WIDTH + FLAG_W + 4;

    localparam logic [PW-1:0] PTR_TOP = PW'(NBYTES - 1);
    localparam logic [3:0]    OP_LAST = 4'(NUM_OPS - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    // Button order: load_a, load_b, op_next, op_prev, exec.
    logic [4:0] btn_level;
    logic [4:0] btn_pulse;
    assign btn_level = {exec, op_prev, op_next, load_b, load_a};

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_edge
            edge_pulse u_edge (
                .clk     (clk),
                .reset_n (reset_n),
                .level_i (btn_level[gi]),
                .pulse_o (btn_pulse[gi])
            );
        end
    endgenerate

    logic load_a_p, load_b_p, op_next_p, op_prev_p, exec_p;
    assign {exec_p, op_prev_p, op_next_p, load_b_p, load_a_p} = btn_pulse;

    logic [WIDTH-1:0]  a_q, b_q;
    logic [PW-1:0]     ptr_a_q, ptr_b_q;
    logic [3:0]        op_index_q;
    logic [AW-1:0]     wr_ptr_q;
    logic [CW-1:0]     hist_count_q;
    logic              hist_valid_q;
    logic [EW-1:0]     hist_data_q;
    logic [EW-1:0]     hist_mem [DEPTH];

    logic [AW-1:0]     rd_idx_d;
    logic              hist_valid_d;
    assign rd_idx_d     = wr_ptr_q - AW'(1) - hist_sel;
    assign hist_valid_d = ({1'b0, hist_sel} < hist_count_q);

    always_ff @(posedge clk) begin
        if (exec_p) begin
            hist_mem[wr_ptr_q] <= {alu_result, alu_flags, op_index_q};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q          <= INIT_A;
            b_q          <= INIT_B;
            ptr_a_q      <= PTR_TOP;
            ptr_b_q      <= PTR_TOP;
            op_index_q   <= 4'd0;
            wr_ptr_q     <= '0;
            hist_count_q <= '0;
            hist_valid_q <= 1'b0;
            hist_data_q  <= '0;
        end else begin
            if (load_a_p) begin
                a_q[{ptr_a_q, 3'b000} +: 8] <= sw;
                ptr_a_q <= (ptr_a_q == '0) ? PTR_TOP : ptr_a_q - PW'(1);
            end
            if (load_b_p) begin
                b_q[{ptr_b_q, 3'b000} +: 8] <= sw;
                ptr_b_q <= (ptr_b_q == '0) ? PTR_TOP : ptr_b_q - PW'(1);
            end
            case ({op_next_p, op_prev_p})
                2'b10:   op_index_q <= (op_index_q == OP_LAST) ? 4'd0 : op_index_q + 4'd1;
                2'b01:   op_index_q <= (op_index_q == 4'd0) ? OP_LAST : op_index_q - 4'd1;
                default: op_index_q <= op_index_q;
            endcase
            if (exec_p) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
                if (hist_count_q != CNT_MAX) begin
                    hist_count_q <= hist_count_q + CW'(1);
                end
            end
            hist_valid_q <= hist_valid_d;
            hist_data_q  <= hist_valid_d ? hist_mem[rd_idx_d] : '0;
        end
    end

    assign a           = a_q;
    assign b           = b_q;
    assign ptr_a       = ptr_a_q;
    assign ptr_b       = ptr_b_q;
    assign op_index    = op_index_q;
    assign opcode      = op_table(op_index_q);
    assign hist_count  = hist_count_q;
    assign hist_valid  = hist_valid_q;
    assign hist_result = hist_data_q[EW-1 -: WIDTH];
    assign hist_flags  = hist_data_q[4 +: FLAG_W];
    assign hist_op     = hist_data_q[3:0];

endmodule

// File: tb/tb_alu_test_console.sv
// Directed bench for alu_test_console: 16-bit and 32-bit instances driven from shared controls.
module tb_alu_test_console;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  sw = 8'h00;
    logic        load_a = 1'b0, load_b = 1'b0, op_next = 1'b0, op_prev = 1'b0, exec = 1'b0;
    logic [2:0]  hist_sel = 3'd0;
    logic [15:0] res_drv = 16'h0000;
    logic        use_model = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    logic [15:0] a16, b16, hres16;
    logic [7:0]  opc16;
    logic [3:0]  opi16, hop16;
    logic [1:0]  pa16, pb16;
    logic [3:0]  hcnt16;
    logic        hval16;
    logic [4:0]  hfl16;
    logic [15:0] alu_res16;

    // Stand-in ALU: bitwise NOT of b lets the same-cycle exec/load_b case show which b was used.
    assign alu_res16 = use_model ? ~b16 : res_drv;

    alu_test_console dut (
        .clk(clk), .reset_n(reset_n), .sw(sw),
        .load_a(load_a), .load_b(load_b), .op_next(op_next), .op_prev(op_prev), .exec(exec),
        .alu_result(alu_res16), .alu_flags(res_drv[4:0]), .hist_sel(hist_sel),
        .a(a16), .b(b16), .opcode(opc16), .op_index(opi16),
        .ptr_a(pa16), .ptr_b(pb16), .hist_count(hcnt16), .hist_valid(hval16),
        .hist_result(hres16), .hist_flags(hfl16), .hist_op(hop16)
    );

    logic [31:0] a32, b32, hres32;
    logic [7:0]  opc32;
    logic [3:0]  opi32, hop32;
    logic [2:0]  pa32, pb32;
    logic [3:0]  hcnt32;
    logic        hval32;
    logic [4:0]  hfl32;

    alu_test_console #(
        .WIDTH(32), .INIT_A(32'hDEADBEEF), .INIT_B(32'h01020304)
    ) dut32 (
        .clk(clk), .reset_n(reset_n), .sw(sw),
        .load_a(load_a), .load_b(load_b), .op_next(op_next), .op_prev(op_prev), .exec(exec),
        .alu_result({16'h0000, res_drv}), .alu_flags(res_drv[4:0]), .hist_sel(hist_sel),
        .a(a32), .b(b32), .opcode(opc32), .op_index(opi32),
        .ptr_a(pa32), .ptr_b(pb32), .hist_count(hcnt32), .hist_valid(hval32),
        .hist_result(hres32), .hist_flags(hfl32), .hist_op(hop32)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
        $display("check %-14s got %0h want %0h", tag, obs, exp);
    endtask

    // mask bits: [0] load_a [1] load_b [2] op_next [3] op_prev [4] exec
    task automatic press(input logic [4:0] mask);
        {exec, op_prev, op_next, load_b, load_a} = mask;
        @(negedge clk);
        {exec, op_prev, op_next, load_b, load_a} = 5'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic sel(input logic [2:0] s);
        hist_sel = s;
        @(negedge clk);
    endtask

    initial begin
        // Reset with load_a held high across release.
        load_a = 1'b1;
        do_reset();
        chk("rst_a", a16, 16'hCAFE);
        chk("rst_ptr_a", pa16, 2'd1);
        chk("rst_op_index", opi16, 4'd0);
        chk("rst_opcode", opc16, 8'h10);
        chk("rst_count", hcnt16, 4'd0);
        chk("rst_hvalid", hval16, 1'b0);
        chk("rst_hresult", hres16, 16'h0);
        chk("rst_a32", a32, 32'hDEADBEEF);
        chk("rst_ptr_a32", pa32, 3'd3);
        load_a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("fall_no_load", a16, 16'hCAFE);

        // Four byte loads: full operand on the 32-bit build, two wraps on 16-bit.
        sw = 8'h12; press(5'b00001);
        sw = 8'h34; press(5'b00001);
        sw = 8'h56; press(5'b00001);
        sw = 8'h78; press(5'b00001);
        chk("a32_load", a32, 32'h12345678);
        chk("ptr_a32_wrap", pa32, 3'd3);
        chk("a16_4loads", a16, 16'h5678);

        res_drv = 16'h0042;
        press(5'b10000);
        sel(3'd3);
        chk("a32_sel3_val", hval32, 1'b0);
        chk("a32_sel3_res", hres32, 32'h0);
        chk("a32_sel3_flg", hfl32, 5'h0);
        sel(3'd0);
        chk("a32_sel0_val", hval32, 1'b1);
        chk("a32_sel0_res", hres32, 32'h42);
        chk("a32_sel0_flg", hfl32, 5'h02);

        // Reset mid-operation clears state and history.
        do_reset();
        chk("rst2_a", a16, 16'hCAFE);
        chk("rst2_count", hcnt16, 4'd0);
        chk("rst2_hvalid", hval16, 1'b0);

        sw = 8'hAB; press(5'b00001);
        chk("a_AB", a16, 16'hABFE);
        chk("ptr_a_0", pa16, 2'd0);
        sw = 8'hCD; press(5'b00001);
        chk("a_ABCD", a16, 16'hABCD);
        chk("ptr_a_1", pa16, 2'd1);
        sw = 8'hBE; press(5'b00001);
        sw = 8'hEF; press(5'b00001);
        chk("a_BEEF", a16, 16'hBEEF);

        press(5'b01000);
        chk("op_prev_wrap", opi16, 4'd6);
        chk("opcode_xor", opc16, 8'h70);
        press(5'b01100);
        chk("op_both", opi16, 4'd6);
        press(5'b00100);
        chk("op_next_wrap", opi16, 4'd0);
        press(5'b01000);

        for (int i = 1; i <= 9; i++) begin
            res_drv = 16'(i);
            press(5'b10000);
        end
        chk("hist_count_sat", hcnt16, 4'd8);
        sel(3'd0);
        chk("sel0_valid", hval16, 1'b1);
        chk("sel0_result", hres16, 16'd9);
        chk("sel0_flags", hfl16, 5'd9);
        chk("sel0_op", hop16, 4'd6);
        sel(3'd7);
        chk("sel7_result", hres16, 16'd2);
        chk("sel7_flags", hfl16, 5'd2);

        // exec and load_b together: entry sees the old b.
        use_model = 1'b1;
        sw = 8'h55;
        press(5'b10010);
        chk("b_after", b16, 16'h5534);
        chk("ptr_b_after", pb16, 2'd0);
        sel(3'd0);
        chk("same_cyc_res", hres16, 16'hEDCB);
        chk("same_cyc_cnt", hcnt16, 4'd8);
        sel(3'd1);
        chk("sel1_result", hres16, 16'd9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
